// File: rtl/ula_pkg.sv
// Shared constants for the ULA front-end: operand/result widths, opcodes and
// the operand-entry FSM state encoding (also shown on the estado LEDs).
package ula_pkg;

  localparam int unsigned W_OPER = 4;
  localparam int unsigned W_RES  = 8;

  localparam logic [W_OPER-1:0] OP_SOMA = 4'd0;
  localparam logic [W_OPER-1:0] OP_SUB  = 4'd1;
  localparam logic [W_OPER-1:0] OP_MUL  = 4'd2;
  localparam logic [W_OPER-1:0] OP_DIV  = 4'd3;
  localparam logic [W_OPER-1:0] OP_SHL  = 4'd4;
  localparam logic [W_OPER-1:0] OP_SHR  = 4'd5;

  typedef enum logic [2:0] {
    CARREGA_OP = 3'd0,
    CARREGA_A  = 3'd1,
    CARREGA_B  = 3'd2,
    CALCULA    = 3'd3,
    EXIBE      = 3'd4
  } estado_t;

endpackage

// File: rtl/ula_sincronizador.sv
// Multi-flop synchroniser for asynchronous board inputs; every stage resets to 0.
module ula_sincronizador #(
  parameter int unsigned WIDTH       = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [SYNC_STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/ula_ctrl_entrada.sv
// Switch/button front-end for the combinational ULA: loads opcode, A and B on
// button presses, latches the result and counts operations.
// Optional divide-by-zero flag output enabled with ULA_CTRL_DIV0_FLAG_EN.
module ula_ctrl_entrada
  import ula_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned NUM_OPS     = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [W_OPER-1:0] switchs,
  input  logic              botao,
  input  logic              cancelar,
  input  logic [W_RES-1:0]  saida_ula,
  output logic [W_OPER-1:0] A,
  output logic [W_OPER-1:0] B,
  output logic [W_OPER-1:0] op,
  output logic [W_RES-1:0]  resultado,
  output logic              valido,
  output logic [2:0]        estado,
`ifdef ULA_CTRL_DIV0_FLAG_EN
  output logic              div0,
`endif
  output logic              erro_op,
  output logic [W_RES-1:0]  contador_ops
);

  logic [W_OPER-1:0] sw_sync;
  logic [1:0]        btn_sync;
  logic              botao_sync;
  logic              canc_sync;
  logic              botao_prev;
  logic              press;

  estado_t state, nxt;
  logic    ld_op, ld_a, ld_b, fim_calc, ack, rej;
  logic    op_ok;
  logic    div_zero;

  ula_sincronizador #(
    .WIDTH       (W_OPER),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_sw (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (switchs),
    .q     (sw_sync)
  );

  ula_sincronizador #(
    .WIDTH       (2),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({cancelar, botao}),
    .q     (btn_sync)
  );

  assign botao_sync = btn_sync[0];
  assign canc_sync  = btn_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) botao_prev <= 1'b0;
    else        botao_prev <= botao_sync;
  end

  // Rising edge only: a held button yields a single press
  assign press = botao_sync & ~botao_prev;
  assign op_ok = 32'(sw_sync) < NUM_OPS;

`ifdef ULA_CTRL_DIV0_FLAG_EN
  assign div_zero = (op == OP_DIV) && (B == '0);
`else
  assign div_zero = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= CARREGA_OP;
    else        state <= nxt;
  end

  // Cancel overrides any press in the same cycle; CALCULA ignores presses
  always_comb begin
    nxt      = state;
    ld_op    = 1'b0;
    ld_a     = 1'b0;
    ld_b     = 1'b0;
    fim_calc = 1'b0;
    ack      = 1'b0;
    rej      = 1'b0;
    if (canc_sync) begin
      nxt = CARREGA_OP;
    end else begin
      case (state)
        CARREGA_OP: if (press) begin
          if (op_ok) begin
            ld_op = 1'b1;
            nxt   = CARREGA_A;
          end else begin
            rej = 1'b1;
          end
        end
        CARREGA_A: if (press) begin
          ld_a = 1'b1;
          nxt  = CARREGA_B;
        end
        CARREGA_B: if (press) begin
          ld_b = 1'b1;
          nxt  = CALCULA;
        end
        CALCULA: begin
          fim_calc = 1'b1;
          nxt      = EXIBE;
        end
        EXIBE: if (press) begin
          ack = 1'b1;
          nxt = CARREGA_OP;
        end
        default: nxt = CARREGA_OP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      A            <= '0;
      B            <= '0;
      op           <= '0;
      resultado    <= '0;
      valido       <= 1'b0;
      erro_op      <= 1'b0;
      contador_ops <= '0;
    end else begin
      if (ld_op) op <= sw_sync;
      if (ld_a)  A  <= sw_sync;
      if (ld_b)  B  <= sw_sync;
      erro_op <= rej;
      if (canc_sync || ack) begin
        valido <= 1'b0;
      end else if (fim_calc) begin
        resultado    <= div_zero ? '0 : saida_ula;
        valido       <= 1'b1;
        contador_ops <= contador_ops + 1'b1;
      end
    end
  end

`ifdef ULA_CTRL_DIV0_FLAG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 div0 <= 1'b0;
    else if (canc_sync || ack)  div0 <= 1'b0;
    else if (fim_calc)          div0 <= div_zero;
  end
`endif

  assign estado = state;

endmodule

// File: tb/tb_ula_ctrl_entrada.sv
// Directed self-checking bench for ula_ctrl_entrada with a behavioural ULA
// driving saida_ula from the controller's A/B/op outputs.
module tb_ula_ctrl_entrada;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] switchs;
  logic       botao;
  logic       cancelar;
  logic [7:0] saida_ula;
  logic [3:0] a_w, b_w, op_w;
  logic [7:0] resultado;
  logic       valido;
  logic [2:0] estado;
  logic       erro_op;
  logic [7:0] contador_ops;
`ifdef ULA_CTRL_DIV0_FLAG_EN
  logic       div0;
`endif

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  ula_ctrl_entrada #(
    .SYNC_STAGES (2),
    .NUM_OPS     (6)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .switchs      (switchs),
    .botao        (botao),
    .cancelar     (cancelar),
    .saida_ula    (saida_ula),
    .A            (a_w),
    .B            (b_w),
    .op           (op_w),
    .resultado    (resultado),
    .valido       (valido),
    .estado       (estado),
`ifdef ULA_CTRL_DIV0_FLAG_EN
    .div0         (div0),
`endif
    .erro_op      (erro_op),
    .contador_ops (contador_ops)
  );

  always_comb begin
    saida_ula = 8'h00;
    case (op_w)
      4'd0: saida_ula = {4'b0, a_w} + {4'b0, b_w};
      4'd1: saida_ula = {4'b0, a_w} - {4'b0, b_w};
      4'd2: saida_ula = {4'b0, a_w} * {4'b0, b_w};
      4'd3: saida_ula = (b_w == 4'd0) ? 8'hFF : {4'b0, a_w / b_w};
      4'd4: saida_ula = {4'b0, a_w} << b_w;
      4'd5: saida_ula = {4'b0, a_w} >> b_w;
      default: saida_ula = 8'h00;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] sw);
    switchs = sw;
    botao   = 1'b1;
    step(5);
    botao   = 1'b0;
    step(5);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_A"}, 32'(a_w), 0);
    chk({tag, "_B"}, 32'(b_w), 0);
    chk({tag, "_op"}, 32'(op_w), 0);
    chk({tag, "_res"}, 32'(resultado), 0);
    chk({tag, "_valido"}, 32'(valido), 0);
    chk({tag, "_estado"}, 32'(estado), 0);
    chk({tag, "_erro"}, 32'(erro_op), 0);
    chk({tag, "_cnt"}, 32'(contador_ops), 0);
  endtask

  initial begin
    int pulses;
    int waited;
    rst_n    = 1'b0;
    switchs  = 4'd0;
    botao    = 1'b0;
    cancelar = 1'b0;
    step(3);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    step(3);

    // add 4+1
    press(4'b0000);
    chk("seq_op", 32'(op_w), 0);
    chk("seq_estado_a", 32'(estado), 1);
    press(4'b0100);
    chk("seq_A", 32'(a_w), 4);
    switchs = 4'b0001;
    botao   = 1'b1;
    waited  = 0;
    while (estado != 3'd3 && waited < 10) begin step(1); waited++; end
    chk("seq_calcula_seen", 32'(estado), 3);
    chk("seq_B", 32'(b_w), 1);
    chk("seq_valido_calc", 32'(valido), 0);
    step(1);
    chk("seq_estado_exibe", 32'(estado), 4);
    chk("seq_res", 32'(resultado), 32'h05);
    chk("seq_valido", 32'(valido), 1);
    chk("seq_cnt", 32'(contador_ops), 1);
    step(4);
    botao = 1'b0;
    step(5);
    chk("seq_hold_exibe", 32'(estado), 4);
    press(4'b0000);
    chk("ack_estado", 32'(estado), 0);
    chk("ack_valido", 32'(valido), 0);
    chk("ack_res_kept", 32'(resultado), 32'h05);

    // invalid opcode
    switchs = 4'b0111;
    botao   = 1'b1;
    pulses  = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (erro_op) pulses++;
    end
    botao = 1'b0;
    step(5);
    chk("inv_pulses", 32'(pulses), 1);
    chk("inv_estado", 32'(estado), 0);
    chk("inv_op", 32'(op_w), 0);

    // 15*15
    press(4'b0010);
    press(4'b1111);
    press(4'b1111);
    chk("mul_res", 32'(resultado), 32'hE1);
    chk("mul_valido", 32'(valido), 1);
    chk("mul_cnt", 32'(contador_ops), 2);
    press(4'b0000);

    // held button in CARREGA_A
    press(4'b0000);
    switchs = 4'b1000;
    botao   = 1'b1;
    step(20);
    botao   = 1'b0;
    step(5);
    chk("held_A", 32'(a_w), 8);
    chk("held_estado", 32'(estado), 2);

    // cancel together with a press in CARREGA_B
    switchs  = 4'b0101;
    cancelar = 1'b1;
    botao    = 1'b1;
    step(5);
    chk("canc_estado", 32'(estado), 0);
    chk("canc_valido", 32'(valido), 0);
    chk("canc_A", 32'(a_w), 8);
    chk("canc_B", 32'(b_w), 15);
    chk("canc_cnt", 32'(contador_ops), 2);
    botao    = 1'b0;
    cancelar = 1'b0;
    step(5);
    chk("canc_after", 32'(estado), 0);

    // async reset during CALCULA
    press(4'b0001);
    press(4'b0010);
    switchs = 4'b0011;
    botao   = 1'b1;
    waited  = 0;
    while (estado != 3'd3 && waited < 10) begin step(1); waited++; end
    chk("rst_calcula_seen", 32'(estado), 3);
    #1 rst_n = 1'b0;
    #1 chk_reset_vals("async");
    botao = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(3);

    // 256 subtractions 2-3, counter wraps
    for (int i = 0; i < 256; i++) begin
      press(4'b0001);
      press(4'b0010);
      press(4'b0011);
      chk("wrap_res", 32'(resultado), 32'hFF);
      chk("wrap_cnt", 32'(contador_ops), 32'((i + 1) % 256));
      press(4'b0000);
    end
    chk("wrap_final", 32'(contador_ops), 0);

`ifdef ULA_CTRL_DIV0_FLAG_EN
    press(4'b0011);
    press(4'b0001);
    press(4'b0000);
    chk("div0_flag", 32'(div0), 1);
    chk("div0_res", 32'(resultado), 0);
    chk("div0_valido", 32'(valido), 1);
    press(4'b0000);
    chk("div0_clear", 32'(div0), 0);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
